// File: rtl/detect7b_pkg.sv
// Shared types and constants for the 7-byte pattern detector sequencer.
package detect7b_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOP,
      SCAN,
      DRAIN
   } state_e;

   localparam logic [7:0] CTRL_HDR  = 8'hFF;
   localparam logic [7:0] CTRL_DATA = 8'h00;

   localparam int unsigned DEF_DATA_W  = 64;
   localparam int unsigned DEF_CTRL_W  = 8;
   localparam int unsigned DEF_CNT_W   = 32;
   localparam int unsigned DEF_IDX_W   = 16;
   localparam int unsigned DEF_DET_LAT = 2;

endpackage

// File: rtl/detect7b_word_tracker.sv
// Packet framing tracker: in-packet flag from the ctrl byte plus a saturating
// data-word index that restarts on the first word of every packet.
module detect7b_word_tracker
   import detect7b_pkg::*;
#(
   parameter int unsigned CTRL_W = DEF_CTRL_W,
   parameter int unsigned IDX_W  = DEF_IDX_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_wr_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic              idx_inc_i,
   output logic              in_pkt_o,
   output logic              sop_o,
   output logic              eop_wr_o,
   output logic              is_hdr_o,
   output logic [IDX_W-1:0]  word_idx_o
);

   localparam logic [CTRL_W-1:0] HDR  = CTRL_W'(CTRL_HDR);
   localparam logic [CTRL_W-1:0] DATA = CTRL_W'(CTRL_DATA);

   logic             in_pkt_q, in_pkt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             is_eop;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         in_pkt_q <= 1'b0;
         idx_q    <= '0;
      end else begin
         in_pkt_q <= in_pkt_d;
         idx_q    <= idx_d;
      end
   end

   always_comb begin
      is_eop   = (in_ctrl_i != HDR) && (in_ctrl_i != DATA);
      in_pkt_d = in_pkt_q;
      if (in_wr_i) begin
         in_pkt_d = !is_eop;
      end
      idx_d = idx_q;
      if (in_wr_i && !in_pkt_q) begin
         idx_d = '0;
      end else if (idx_inc_i && (idx_q != '1)) begin
         idx_d = idx_q + 1'b1;
      end
   end

   assign in_pkt_o   = in_pkt_q;
   assign sop_o      = in_wr_i && !in_pkt_q;
   assign eop_wr_o   = in_wr_i && is_eop;
   assign is_hdr_o   = (in_ctrl_i == HDR);
   assign word_idx_o = idx_q;

endmodule

// File: rtl/detect7b_match_ctrl.sv
// Sequencer for the 7-byte pattern detector: arms on software pulse, frames
// packets, drives detector ce/match_en/mrst and keeps hit/packet counters.
// Optional build macro DETECT7B_STOP_ON_HIT_EN: auto-disarm after a hit packet.
module detect7b_match_ctrl
   import detect7b_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned CTRL_W  = DEF_CTRL_W,
   parameter int unsigned CNT_W   = DEF_CNT_W,
   parameter int unsigned IDX_W   = DEF_IDX_W,
   parameter int unsigned DET_LAT = DEF_DET_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sw_pattern,
   input  logic              sw_arm,
   input  logic              sw_disarm,
   input  logic              sw_clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_wr,
   output logic [DATA_W-1:0] det_pattern,
   output logic              det_ce,
   output logic              det_match_en,
   output logic              det_mrst,
   input  logic              det_match,
   output logic              busy,
   output logic              hit_flag,
   output logic [IDX_W-1:0]  hit_word_idx,
   output logic [CNT_W-1:0]  match_count,
   output logic [CNT_W-1:0]  pkt_count
);

   localparam int unsigned DRAIN_W = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   pattern_q, pattern_d;
   logic [DRAIN_W-1:0]  drain_q, drain_d;
   logic                pkt_hit_q, pkt_hit_d;
   logic                hit_flag_q, hit_flag_d;
   logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
   logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;

   logic                in_pkt, sop, eop_wr, is_hdr;
   logic [IDX_W-1:0]    word_idx;
   logic                drain_last, hit_now, pkt_hit_any, count_upd, scanning;
   logic                unused_data;

   assign unused_data = ^in_data;

   detect7b_word_tracker #(
      .CTRL_W (CTRL_W),
      .IDX_W  (IDX_W)
   ) u_tracker (
      .clk_i      (clk),
      .rst_i      (reset),
      .in_wr_i    (in_wr),
      .in_ctrl_i  (in_ctrl),
      .idx_inc_i  (det_ce),
      .in_pkt_o   (in_pkt),
      .sop_o      (sop),
      .eop_wr_o   (eop_wr),
      .is_hdr_o   (is_hdr),
      .word_idx_o (word_idx)
   );

   assign scanning    = (state_q == SCAN) || (state_q == DRAIN);
   assign drain_last  = (state_q == DRAIN) && (drain_q == DRAIN_W'(DET_LAT - 1));
   assign hit_now     = scanning && det_match && !pkt_hit_q && !sw_disarm;
   assign pkt_hit_any = pkt_hit_q || hit_now;
   assign count_upd   = drain_last && !sw_disarm;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // SCAN entered with in_pkt low means the starting word already carried EOP.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (sw_arm) state_d = WAIT_SOP;
         WAIT_SOP: if (sop) state_d = SCAN;
         SCAN:     if (!in_pkt || eop_wr) state_d = DRAIN;
         DRAIN: begin
            if (drain_last) begin
`ifdef DETECT7B_STOP_ON_HIT_EN
               state_d = pkt_hit_any ? IDLE : WAIT_SOP;
`else
               state_d = WAIT_SOP;
`endif
            end
         end
         default:  state_d = IDLE;
      endcase
      if (sw_disarm) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      det_ce       = (state_q == SCAN) && in_wr && in_pkt && !is_hdr;
      det_match_en = scanning;
      det_mrst     = (state_q == IDLE) || drain_last;
      busy         = (state_q != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pattern_q   <= '0;
         drain_q     <= '0;
         pkt_hit_q   <= 1'b0;
         hit_flag_q  <= 1'b0;
         hit_idx_q   <= '0;
         match_cnt_q <= '0;
         pkt_cnt_q   <= '0;
      end else begin
         pattern_q   <= pattern_d;
         drain_q     <= drain_d;
         pkt_hit_q   <= pkt_hit_d;
         hit_flag_q  <= hit_flag_d;
         hit_idx_q   <= hit_idx_d;
         match_cnt_q <= match_cnt_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   // Clear is applied before the end-of-packet update so a same-cycle hit survives.
   always_comb begin
      pattern_d = pattern_q;
      if ((state_q == IDLE) && sw_arm && !sw_disarm) begin
         pattern_d = sw_pattern;
      end

      drain_d   = (state_q == DRAIN) ? drain_q + 1'b1 : '0;
      pkt_hit_d = scanning ? pkt_hit_any : 1'b0;

      hit_flag_d  = sw_clear ? 1'b0 : hit_flag_q;
      match_cnt_d = sw_clear ? '0 : match_cnt_q;
      pkt_cnt_d   = sw_clear ? '0 : pkt_cnt_q;
      hit_idx_d   = hit_idx_q;

      if (hit_now) begin
         hit_flag_d = 1'b1;
         hit_idx_d  = (word_idx >= IDX_W'(DET_LAT)) ? word_idx - IDX_W'(DET_LAT) : '0;
      end
      if (count_upd) begin
         pkt_cnt_d = pkt_cnt_d + 1'b1;
         if (pkt_hit_any) begin
            match_cnt_d = match_cnt_d + 1'b1;
         end
      end
   end

   assign det_pattern  = pattern_q;
   assign hit_flag     = hit_flag_q;
   assign hit_word_idx = hit_idx_q;
   assign match_count  = match_cnt_q;
   assign pkt_count    = pkt_cnt_q;

endmodule
